// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/LSU memory port arbiter.
// State encodings and owner codes are shared by the arbiter and its bench.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_IF = 2'd1,
      ST_BUSY_D  = 2'd2
   } state_e;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   // Picks the 32-bit instruction word out of a 64-bit memory beat.
   function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] beat);
      return hi ? beat[63:32] : beat[31:0];
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Timeout counter for an outstanding memory request; `expired` is asserted
// combinationally in the last allowed BUSY cycle.
module mem_arb_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CW{1'b0}};
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// drives the memory handshake and returns responses (or timeout errors).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int TIMEOUT      = 16,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   output logic          if_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [63:0]   d_wdata,
   input  logic [7:0]    d_wstrb,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [63:0]   d_rdata,
   output logic          d_err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [63:0]   mem_wdata,
   output logic [7:0]    mem_wstrb,
   input  logic          mem_ack,
   input  logic [63:0]   mem_rdata,
   output logic          busy,
   output logic          owner
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [AW-1:0] ALIGN_MASK = {{(AW-3){1'b1}}, 3'b000};

   state_e state_q, state_d;

   logic          if_gnt_s, d_gnt_s, ack_s, expired_s, done_s, idle_s;
   logic [SW-1:0] starve_q, starve_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [63:0]   mem_wdata_q, mem_wdata_d;
   logic [7:0]    mem_wstrb_q, mem_wstrb_d;
   logic          if_sel_q, if_sel_d, owner_q, owner_d;
   logic          if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic          d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
   logic [63:0]   d_rdata_q, d_rdata_d;

   assign idle_s = (state_q == ST_IDLE);
   assign ack_s  = !idle_s && mem_ack;
   assign done_s = ack_s || expired_s;

   // Grants are combinational and masked while reset is held so every output reads 0.
   always_comb begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
      if (!rst && idle_s) begin
         if (if_req && (!d_req || (starve_q == STARVE_MAX))) begin
            if_gnt_s = 1'b1;
         end else if (d_req) begin
            d_gnt_s = 1'b1;
         end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
         end
      end else begin
         if_gnt_s = 1'b0;
         d_gnt_s  = 1'b0;
      end
   end

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (idle_s),
      .en      (!idle_s),
      .expired (expired_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; an ack in the timeout cycle still counts as a normal completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (if_gnt_s) begin
               state_d = ST_BUSY_IF;
            end else if (d_gnt_s) begin
               state_d = ST_BUSY_D;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY_IF, ST_BUSY_D: begin
            if (done_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: payload latches, starvation count and response registers.
   always_comb begin
      starve_d    = starve_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_sel_d    = if_sel_q;
      owner_d     = owner_q;
      if_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      if_err_d    = if_err_q;
      d_rvalid_d  = 1'b0;
      d_rdata_d   = d_rdata_q;
      d_err_d     = d_err_q;
      mem_req_d   = (state_d != ST_IDLE);

      if (if_gnt_s) begin
         starve_d    = {SW{1'b0}};
         mem_we_d    = 1'b0;
         mem_addr_d  = if_addr & ALIGN_MASK;
         mem_wdata_d = 64'd0;
         mem_wstrb_d = 8'h00;
         if_sel_d    = if_addr[2];
         owner_d     = OWN_IF;
      end else if (d_gnt_s) begin
         if (if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
         end else begin
            starve_d = starve_q;
         end
         mem_we_d    = d_we;
         mem_addr_d  = d_addr & ALIGN_MASK;
         mem_wdata_d = d_we ? d_wdata : 64'd0;
         mem_wstrb_d = d_we ? d_wstrb : 8'h00;
         owner_d     = OWN_D;
      end else begin
         starve_d = starve_q;
      end

      case (state_q)
         ST_BUSY_IF: begin
            if (done_s) begin
               if_rvalid_d = 1'b1;
               if_rdata_d  = ack_s ? fetch_word(if_sel_q, mem_rdata) : 32'd0;
               if_err_d    = !ack_s;
            end else begin
               if_rvalid_d = 1'b0;
            end
         end
         ST_BUSY_D: begin
            if (done_s) begin
               d_rvalid_d = 1'b1;
               d_rdata_d  = (ack_s && !mem_we_q) ? mem_rdata : 64'd0;
               d_err_d    = !ack_s;
            end else begin
               d_rvalid_d = 1'b0;
            end
         end
         default: begin
            if_rvalid_d = 1'b0;
            d_rvalid_d  = 1'b0;
         end
      endcase
   end

   // Output and payload registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q    <= {SW{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {AW{1'b0}};
         mem_wdata_q <= 64'd0;
         mem_wstrb_q <= 8'h00;
         if_sel_q    <= 1'b0;
         owner_q     <= OWN_IF;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'd0;
         if_err_q    <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= 64'd0;
         d_err_q     <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_sel_q    <= if_sel_d;
         owner_q     <= owner_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         d_rvalid_q  <= d_rvalid_d;
         d_rdata_q   <= d_rdata_d;
         d_err_q     <= d_err_d;
      end
   end

   assign if_gnt    = if_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign busy      = !idle_s;
   assign owner     = owner_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
   logic [AW-1:0] if_addr = '0, d_addr = '0;
   logic [63:0]   d_wdata = '0, mem_rdata = '0;
   logic [7:0]    d_wstrb = '0;
   logic          if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
   logic          mem_req, mem_we, busy, owner;
   logic [31:0]   if_rdata;
   logic [63:0]   d_rdata, mem_wdata;
   logic [7:0]    mem_wstrb;
   logic [AW-1:0] mem_addr;

   typedef struct packed {
      logic        is_if;
      logic [63:0] rdata;
      logic        err;
   } resp_t;

   resp_t exp_q[$];
   int    tests = 0;
   int    fails = 0;

   mem_port_arbiter #(.AW(AW), .TIMEOUT(16), .STARVE_LIMIT(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_resp(input logic is_if, input logic [63:0] rdata, input logic err);
      resp_t r;
      r.is_if = is_if;
      r.rdata = rdata;
      r.err   = err;
      exp_q.push_back(r);
   endtask

   // Scoreboard: every response pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (!rst && (if_rvalid || d_rvalid)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("resp_port", {63'd0, if_rvalid}, {63'd0, e.is_if});
            check("resp_rdata", e.is_if ? {32'd0, if_rdata} : d_rdata, e.rdata);
            check("resp_err", {63'd0, e.is_if ? if_err : d_err}, {63'd0, e.err});
         end
      end
   end

   initial begin
      logic [63:0] beat;
      logic        exp_if;

      // Reset: a pending request must not produce a grant while reset is held.
      if_req = 1'b1;
      @(negedge clk);
      #1;
      check("rst_if_gnt", {63'd0, if_gnt}, 64'd0);
      check("rst_ctrl", {60'd0, busy, mem_req, owner, if_rvalid}, 64'd0);
      if_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Single fetch, ack two cycles after the grant.
      if_req = 1'b1;
      if_addr = 32'h0000_0104;
      #1;
      check("f_if_gnt", {63'd0, if_gnt}, 64'd1);
      check("f_d_gnt", {63'd0, d_gnt}, 64'd0);
      push_resp(1'b1, 64'h0000_0000_AAAA_BBBB, 1'b0);
      @(negedge clk);
      if_req = 1'b0;
      check("f_mem_req", {63'd0, mem_req}, 64'd1);
      check("f_mem_addr", {32'd0, mem_addr}, 64'h100);
      check("f_mem_we", {63'd0, mem_we}, 64'd0);
      check("f_owner", {63'd0, owner}, 64'd0);
      @(negedge clk);
      check("f_rvalid_early", {63'd0, if_rvalid}, 64'd0);
      mem_ack = 1'b1;
      mem_rdata = 64'hAAAA_BBBB_1111_2222;
      @(negedge clk);
      mem_ack = 1'b0;
      check("f_rvalid", {63'd0, if_rvalid}, 64'd1);
      check("f_busy_after", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("f_rvalid_pulse", {63'd0, if_rvalid}, 64'd0);
      check("f_rdata_hold", {32'd0, if_rdata}, 64'hAAAA_BBBB);

      // Conflict: both requesters held high, immediate acks.
      if_req = 1'b1;
      d_req = 1'b1;
      if_addr = 32'h0000_0008;
      d_addr = 32'h0000_0010;
      d_we = 1'b0;
      mem_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_if = ((i % 4) == 3);
         beat = {32'hC0DE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
         mem_rdata = beat;
         #1;
         check("c_if_gnt", {63'd0, if_gnt}, {63'd0, exp_if});
         check("c_d_gnt", {63'd0, d_gnt}, {63'd0, !exp_if});
         push_resp(exp_if, exp_if ? {32'd0, beat[31:0]} : beat, 1'b0);
         @(negedge clk);
         check("c_owner", {63'd0, owner}, {63'd0, !exp_if});
         @(negedge clk);
      end
      if_req = 1'b0;
      d_req = 1'b0;
      mem_ack = 1'b0;
      @(negedge clk);

      // Store: strobes and data pass through, response carries zero data.
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 32'h0000_0203;
      d_wdata = 64'h1122_3344_5566_7788;
      d_wstrb = 8'h0F;
      #1;
      check("s_d_gnt", {63'd0, d_gnt}, 64'd1);
      push_resp(1'b0, 64'd0, 1'b0);
      @(negedge clk);
      d_req = 1'b0;
      check("s_mem_addr", {32'd0, mem_addr}, 64'h200);
      check("s_mem_we", {63'd0, mem_we}, 64'd1);
      check("s_mem_wstrb", {56'd0, mem_wstrb}, 64'h0F);
      check("s_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
      mem_ack = 1'b1;
      mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      mem_ack = 1'b0;
      check("s_rvalid", {63'd0, d_rvalid}, 64'd1);
      @(negedge clk);

      // Timeout: load never acked.
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h0000_0300;
      #1;
      check("t_d_gnt", {63'd0, d_gnt}, 64'd1);
      push_resp(1'b0, 64'd0, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         d_req = 1'b0;
         check("t_mem_req_high", {63'd0, mem_req}, 64'd1);
         check("t_no_early_rvalid", {63'd0, d_rvalid}, 64'd0);
      end
      @(negedge clk);
      check("t_mem_req_low", {63'd0, mem_req}, 64'd0);
      check("t_rvalid", {63'd0, d_rvalid}, 64'd1);
      check("t_mem_wstrb_read", {56'd0, mem_wstrb}, 64'd0);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("t_stray_busy", {63'd0, busy}, 64'd0);
      check("t_stray_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
      check("t_err_hold", {63'd0, d_err}, 64'd1);
      @(negedge clk);
      check("t_stray_rvalid2", {62'd0, if_rvalid, d_rvalid}, 64'd0);

      // Reset in the middle of a data transaction.
      d_req = 1'b1;
      d_addr = 32'h0000_0400;
      #1;
      check("r_d_gnt", {63'd0, d_gnt}, 64'd1);
      @(negedge clk);
      d_req = 1'b0;
      check("r_busy", {62'd0, busy, owner}, 64'd3);
      #2;
      rst = 1'b1;
      #1;
      check("r_ctrl_zero", {54'd0, busy, mem_req, owner, if_gnt, d_gnt, if_rvalid,
                            d_rvalid, if_err, d_err, mem_we}, 64'd0);
      check("r_mem_addr_zero", {32'd0, mem_addr}, 64'd0);
      check("r_rdata_zero", d_rdata | {32'd0, if_rdata}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("r_no_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
      check("r_idle", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("r_no_rvalid2", {62'd0, if_rvalid, d_rvalid}, 64'd0);

      // Fresh fetch after reset, upper word selected.
      if_req = 1'b1;
      if_addr = 32'h0000_040C;
      #1;
      check("p_if_gnt", {63'd0, if_gnt}, 64'd1);
      push_resp(1'b1, 64'h0000_0000_5555_6666, 1'b0);
      @(negedge clk);
      if_req = 1'b0;
      check("p_mem_addr", {32'd0, mem_addr}, 64'h408);
      mem_ack = 1'b1;
      mem_rdata = 64'h5555_6666_7777_8888;
      @(negedge clk);
      mem_ack = 1'b0;
      check("p_rvalid", {63'd0, if_rvalid}, 64'd1);
      @(negedge clk);

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
